// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter and sequencer
// for the single MemoryUnit request port.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_we,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_q,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_we,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_q,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mu_address,
  output logic [DATA_W-1:0] mu_data,
  output logic              mu_we,
  output logic              mu_start,
  input  logic              mu_busy,
  input  logic [DATA_W-1:0] mu_q,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [15:0] CNT_END = 16'(TIMEOUT - 1);

  state_t      state;
  logic        last;
  logic        lock_held;
  logic        busy_seen;
  logic [15:0] cnt;
  logic        gnt0;
  logic        gnt1;

  // IDLE-cycle grant; a held lock only survives
  // while master 0 keeps requesting
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_held && m0_req) begin
      gnt0 = 1'b1;
    end else if (m0_req && m1_req) begin
      if (FIXED_PRIO || last) gnt0 = 1'b1;
      else                    gnt1 = 1'b1;
    end else if (m0_req) begin
      gnt0 = 1'b1;
    end else if (m1_req) begin
      gnt1 = 1'b1;
    end
  end

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      mu_start   <= 1'b0;
      mu_we      <= 1'b0;
      mu_address <= '0;
      mu_data    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_q       <= '0;
      m1_q       <= '0;
      owner      <= 1'b0;
      last       <= 1'b1;
      lock_held  <= 1'b0;
      busy_seen  <= 1'b0;
      cnt        <= '0;
    end else begin
      mu_start <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lock_held && !m0_req)
            lock_held <= 1'b0;
          if (gnt0 || gnt1) begin
            mu_address <= gnt1 ? m1_addr : m0_addr;
            mu_data    <= gnt1 ? m1_data : m0_data;
            mu_we      <= gnt1 ? m1_we : m0_we;
            owner      <= gnt1;
            mu_start   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          busy_seen <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (mu_busy) busy_seen <= 1'b1;
          if (busy_seen && !mu_busy) begin
            if (owner) m1_q <= mu_q;
            else       m0_q <= mu_q;
            m0_ack <= !owner;
            m1_ack <= owner;
            state  <= DONE;
          end else if (cnt == CNT_END) begin
            m0_ack <= !owner;
            m1_ack <= owner;
            m0_err <= !owner;
            m1_err <= owner;
            state  <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          last      <= owner;
          lock_held <= !owner && m0_lock;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of the
// round-robin and fixed-priority arbiter builds.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        m0_req = 1'b0;
  logic [26:0] m0_addr = '0;
  logic [31:0] m0_data = '0;
  logic        m0_we = 1'b0;
  logic        m0_lock = 1'b0;
  logic        m1_req = 1'b0;
  logic [26:0] m1_addr = '0;
  logic [31:0] m1_data = '0;
  logic        m1_we = 1'b0;
  logic        mu_busy;
  logic [31:0] mu_q = '0;

  logic        a_m0_ack, a_m1_ack;
  logic        a_m0_err, a_m1_err;
  logic [31:0] a_m0_q, a_m1_q;
  logic [26:0] a_mu_address;
  logic [31:0] a_mu_data;
  logic        a_mu_we, a_mu_start, a_owner;

  logic        b_m0_ack, b_m1_ack;
  logic        b_m0_err, b_m1_err;
  logic [31:0] b_m0_q, b_m1_q;
  logic [26:0] b_mu_address;
  logic [31:0] b_mu_data;
  logic        b_mu_we, b_mu_start, b_owner;

  int n_cmp = 0;
  int n_err = 0;
  int a0cnt = 0;
  int a1cnt = 0;
  int busy_len = 4;
  int bcnt;
  logic stuck = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(27), .DATA_W(32),
    .FIXED_PRIO(1'b0), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .nreset(nreset),
    .m0_req(m0_req), .m0_addr(m0_addr),
    .m0_data(m0_data), .m0_we(m0_we),
    .m0_lock(m0_lock), .m0_ack(a_m0_ack),
    .m0_q(a_m0_q), .m0_err(a_m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr),
    .m1_data(m1_data), .m1_we(m1_we),
    .m1_ack(a_m1_ack), .m1_q(a_m1_q),
    .m1_err(a_m1_err),
    .mu_address(a_mu_address),
    .mu_data(a_mu_data), .mu_we(a_mu_we),
    .mu_start(a_mu_start), .mu_busy(mu_busy),
    .mu_q(mu_q), .owner(a_owner)
  );

  mem_bus_arbiter #(
    .ADDR_W(27), .DATA_W(32),
    .FIXED_PRIO(1'b1), .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .nreset(nreset),
    .m0_req(m0_req), .m0_addr(m0_addr),
    .m0_data(m0_data), .m0_we(m0_we),
    .m0_lock(m0_lock), .m0_ack(b_m0_ack),
    .m0_q(b_m0_q), .m0_err(b_m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr),
    .m1_data(m1_data), .m1_we(m1_we),
    .m1_ack(b_m1_ack), .m1_q(b_m1_q),
    .m1_err(b_m1_err),
    .mu_address(b_mu_address),
    .mu_data(b_mu_data), .mu_we(b_mu_we),
    .mu_start(b_mu_start), .mu_busy(mu_busy),
    .mu_q(mu_q), .owner(b_owner)
  );

  // MemoryUnit stand-in: busy for busy_len cycles
  // starting the cycle after a start strobe
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mu_busy <= 1'b0;
      bcnt    <= 0;
    end else if (a_mu_start && !stuck) begin
      mu_busy <= 1'b1;
      bcnt    <= busy_len - 1;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end else begin
      mu_busy <= 1'b0;
    end
  end

  // ack tallies for the round-robin build
  always @(posedge clk) begin
    if (a_m0_ack) a0cnt <= a0cnt + 1;
    if (a_m1_ack) a1cnt <= a1cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    nreset = 1'b0;
    tick;
    tick;
    nreset = 1'b1;
    tick;
  endtask

  task automatic wait_start(input string tag,
                            output int k);
    logic seen;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick;
      k++;
      seen = a_mu_start;
    end
    chk({tag, " start seen"}, 128'(seen), 128'd1);
  endtask

  task automatic wait_ack(input string tag,
                          output int k);
    logic seen;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick;
      k++;
      seen = a_m0_ack | a_m1_ack;
    end
    chk({tag, " ack seen"}, 128'(seen), 128'd1);
  endtask

  int k;
  int c1;
  int c0;

  initial begin
    tick;
    tick;
    chk("rst a", {a_mu_start, a_mu_we, a_mu_address,
                  a_mu_data, a_m0_ack, a_m1_ack,
                  a_m0_err, a_m1_err, a_owner}, '0);
    chk("rst a q", {a_m0_q, a_m1_q}, '0);
    chk("rst b", {b_mu_start, b_mu_we, b_mu_address,
                  b_mu_data, b_m0_ack, b_m1_ack,
                  b_m0_err, b_m1_err, b_owner}, '0);
    chk("rst b q", {b_m0_q, b_m1_q}, '0);
    nreset = 1'b1;
    tick;

    // single m0 read
    m0_addr  = 27'h0000100;
    m0_we    = 1'b0;
    mu_q     = 32'hDEADBEEF;
    busy_len = 4;
    c1       = a1cnt;
    m0_req   = 1'b1;
    wait_start("t1", k);
    chk("t1 start latency", 128'(k), 128'd1);
    chk("t1 issue", {a_mu_address, a_mu_we},
        {27'h100, 1'b0});
    tick;
    chk("t1 start width", 128'(a_mu_start), 128'd0);
    wait_ack("t1", k);
    chk("t1 ack latency", 128'(k), 128'd5);
    chk("t1 result", {a_m0_ack, a_m1_ack, a_m0_err,
                      a_m0_q, a_owner},
        {1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0});
    m0_req = 1'b0;
    tick;
    chk("t1 ack width", 128'(a_m0_ack), 128'd0);
    chk("t1 no m1 ack", 128'(a1cnt), 128'(c1));

    // both requesting: alternate vs fixed
    do_reset;
    busy_len = 1;
    m0_req   = 1'b1;
    m1_req   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mu_q = 32'hA5A50000 + 32'(i);
      wait_ack("rr", k);
      chk("rr spacing", 128'(k),
          128'((i == 0) ? 4 : 5));
      chk("rr acks", {a_m1_ack, a_m0_ack},
          (i % 2) ? 2'b10 : 2'b01);
      chk("rr q", (i % 2) ? a_m1_q : a_m0_q,
          32'hA5A50000 + 32'(i));
      chk("fp acks", {b_m1_ack, b_m0_ack}, 2'b01);
    end
    m0_req = 1'b0;
    wait_ack("rr tail", k);
    chk("rr tail acks", {a_m1_ack, a_m0_ack}, 2'b10);
    chk("fp tail acks", {b_m1_ack, b_m0_ack}, 2'b10);
    m1_req = 1'b0;
    tick;

    // locked writes from m0 with m1 pending
    do_reset;
    busy_len = 2;
    m0_lock  = 1'b1;
    m0_we    = 1'b1;
    m1_we    = 1'b0;
    m1_addr  = 27'h0000200;
    m0_req   = 1'b1;
    m1_req   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m0_data = 32'hC0DE0000 + 32'(i);
      m0_addr = 27'h0000300 + 27'(i);
      wait_start("lk", k);
      chk("lk issue", {a_mu_we, a_mu_address, a_mu_data},
          {1'b1, 27'h300 + 27'(i),
           32'hC0DE0000 + 32'(i)});
      if (i == 2) m0_lock = 1'b0;
      wait_ack("lk", k);
      chk("lk acks a", {a_m1_ack, a_m0_ack}, 2'b01);
      chk("lk acks b", {b_m1_ack, b_m0_ack}, 2'b01);
    end
    m0_req = 1'b0;
    mu_q   = 32'h5555AAAA;
    wait_start("lk m1", k);
    chk("lk m1 issue", {a_mu_we, a_mu_address},
        {1'b0, 27'h200});
    wait_ack("lk m1", k);
    chk("lk m1 acks", {a_m1_ack, a_m0_ack, a_m1_q},
        {2'b10, 32'h5555AAAA});
    m1_req = 1'b0;
    tick;

    // busy never rises: timeout on m1
    stuck  = 1'b1;
    mu_q   = 32'hBAD0BAD0;
    m1_req = 1'b1;
    wait_start("to", k);
    wait_ack("to", k);
    chk("to latency", 128'(k), 128'd9);
    chk("to result", {a_m1_ack, a_m1_err, a_m0_ack,
                      a_m0_err, a_m1_q, a_owner},
        {4'b1100, 32'h5555AAAA, 1'b1});
    m1_req = 1'b0;
    tick;
    chk("to clear", {a_m1_ack, a_m1_err}, 2'b00);
    stuck    = 1'b0;
    busy_len = 3;
    mu_q     = 32'h12345678;
    m1_req   = 1'b1;
    wait_ack("to next", k);
    chk("to next result", {a_m1_ack, a_m1_err, a_m1_q},
        {2'b10, 32'h12345678});
    m1_req = 1'b0;
    tick;

    // reset in the middle of WAIT
    busy_len = 20;
    m0_addr  = 27'h00007FF;
    m0_req   = 1'b1;
    wait_start("mr", k);
    tick;
    tick;
    c0 = a0cnt;
    nreset = 1'b0;
    #1;
    chk("mr outs", {a_mu_start, a_mu_we, a_mu_address,
                    a_mu_data, a_m0_ack, a_m1_ack,
                    a_m0_err, a_m1_err, a_owner}, '0);
    chk("mr q", {a_m0_q, a_m1_q}, '0);
    m0_req = 1'b0;
    tick;
    tick;
    nreset = 1'b1;
    tick;
    tick;
    chk("mr no ack", 128'(a0cnt), 128'(c0));
    busy_len = 2;
    m1_addr  = 27'h00000AB;
    mu_q     = 32'hFACE0001;
    m1_req   = 1'b1;
    wait_start("mr m1", k);
    chk("mr m1 issue", {a_mu_address, a_owner},
        {27'hAB, 1'b1});
    wait_ack("mr m1", k);
    chk("mr m1 result", {a_m1_ack, a_m1_err, a_owner,
                         a_m1_q},
        {3'b101, 32'hFACE0001});
    m1_req = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
